// File: rtl/core_pkg.sv
// core_pkg: definitions shared across the RV32I core.
//   - sel_jump encodings driven by the control unit into the fetch stage
//   - fetch FSM state type
//   - RV32I major opcode constants used by the control unit and decoder
package core_pkg;

    // sel_jump encodings. The value 2'b11 is reserved and is treated as JUMP_NONE.
    localparam logic [1:0] JUMP_NONE = 2'b00;
    localparam logic [1:0] JUMP_JAL  = 2'b01;
    localparam logic [1:0] JUMP_JALR = 2'b10;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        ISSUED = 2'b01,
        FAULT  = 2'b10
    } fetch_state_t;

    // RV32I major opcodes (instr[6:0]).
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/next_pc_gen.sv
// next_pc_gen: combinational next-PC computation for the retiring instruction.
// Ports:
//   pc           in  32  address of the retiring instruction
//   sel_jump     in  2   JUMP_NONE / JUMP_JAL / JUMP_JALR (2'b11 acts as JUMP_NONE)
//   branch_taken in  1   branch decision, honoured only for JUMP_NONE
//   imm          in  32  sign-extended immediate
//   rs1_val      in  32  rs1 operand for JALR
//   target       out 32  next PC (all adds modulo 2^32)
//   misaligned   out 1   target is not 4-byte aligned
module next_pc_gen
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  sel_jump,
    input  logic        branch_taken,
    input  logic [31:0] imm,
    input  logic [31:0] rs1_val,
    output logic [31:0] target,
    output logic        misaligned
);

    logic [31:0] jalr_sum;

    assign jalr_sum = rs1_val + imm;

    always_comb begin
        target = pc + 32'd4;
        case (sel_jump)
            JUMP_JAL:  target = pc + imm;
            // JALR clears bit 0 of the sum; bit 1 may still be set and fault.
            JUMP_JALR: target = {jalr_sum[31:1], 1'b0};
            default: begin
                if (branch_taken) begin
                    target = pc + imm;
                end
            end
        endcase
    end

    assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage of the RV32I core.
// Holds the PC, fetches one word at a time from instruction memory and hands
// it to decode, then computes the next PC when that instruction retires.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req/imem_addr            fetch request and word address (= pc)
//   imem_ack/imem_rdata           memory response, ignored while imem_req=0
//   instr_valid/instr_ready       handshake towards decode
//   instr/pc_out                  fetched instruction and its address
//   sel_jump/branch_taken/imm/rs1_val  control inputs sampled at retire
//   fault/fault_pc                sticky misaligned-target fault and target
//   retired_cnt                   retired-instruction counter (wraps)
//   state_dbg                     current FSM state
//
// Handshake: an instruction retires in a cycle where instr_valid=1 and
// instr_ready=1. While instr_valid=1 and instr_ready=0, instr, pc_out and
// instr_valid are held unchanged. The memory side completes a fetch in any
// cycle where imem_req=1 and imem_ack=1; imem_req and imem_addr stay stable
// until then.
module instr_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [31:0]       pc_out,
    input  logic [1:0]        sel_jump,
    input  logic              branch_taken,
    input  logic [31:0]       imm,
    input  logic [31:0]       rs1_val,
    output logic              fault,
    output logic [31:0]       fault_pc,
    output logic [CNT_W-1:0]  retired_cnt,
    output fetch_state_t      state_dbg
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic         misaligned;

    next_pc_gen u_next_pc_gen (
        .pc           (pc),
        .sel_jump     (sel_jump),
        .branch_taken (branch_taken),
        .imm          (imm),
        .rs1_val      (rs1_val),
        .target       (target),
        .misaligned   (misaligned)
    );

    assign imem_addr = pc;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b1;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            pc_out      <= 32'h0;
            fault       <= 1'b0;
            fault_pc    <= 32'h0;
            retired_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        pc_out      <= pc;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= ISSUED;
                    end
                end
                ISSUED: begin
                    if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                        retired_cnt <= retired_cnt + CNT_W'(1);
                        if (misaligned) begin
                            // pc keeps the faulting instruction's address.
                            fault    <= 1'b1;
                            fault_pc <= target;
                            state    <= FAULT;
                        end else begin
                            pc       <= target;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                FAULT: begin
                    // Terminal until reset.
                end
                default: begin
                    // Unreachable encoding: park safely with nothing in flight.
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= FAULT;
                end
            endcase
        end
    end

endmodule
